// File: rtl/dac_tx_fifo.sv
// Elastic FIFO between the transmit core and the DAC: prefill, continuous streaming, underrun recovery.
// Define DAC_TX_FIFO_STATUS_EN to drive fifo_level and underrun_count; otherwise both read as zero.
module dac_tx_fifo #(
    parameter  int NUMBER_OF_LINE = 8,
    parameter  int ADDR_WIDTH     = 5,
    localparam int DW             = 2 * 16 * NUMBER_OF_LINE
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [ADDR_WIDTH:0]   prefill_level,
    input  logic [DW-1:0]         s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DW-1:0]         m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic [15:0]           underrun_count
);

    localparam int              DEPTH      = 2 ** ADDR_WIDTH;
    localparam int              CW         = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   FULL_LEVEL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_STREAM,
        ST_UNDERRUN
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]           m_tdata_q, m_tdata_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [DW-1:0]           mem_q [DEPTH];

    logic [CW-1:0]           threshold;
    logic                    wr_en;
    logic                    pop_en;
    logic                    underrun_evt;

    // A zero threshold would skip PREFILL entirely; anything above DEPTH could never be reached.
    always_comb begin
        threshold = prefill_level;
        if (prefill_level == '0) begin
            threshold = CW'(1);
        end else if (prefill_level > FULL_LEVEL) begin
            threshold = FULL_LEVEL;
        end
    end

    // FSM process 1: state register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM process 2: next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:     state_d = ST_PREFILL;
                ST_PREFILL:  if (count_q >= threshold) state_d = ST_STREAM;
                ST_STREAM:   if (underrun_evt) state_d = ST_UNDERRUN;
                ST_UNDERRUN: state_d = ST_PREFILL;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // FSM process 3: outputs and handshake decode, all from registered state and count.
    always_comb begin
        s_tready     = (state_q != ST_IDLE) && (count_q < FULL_LEVEL);
        wr_en        = s_tvalid && s_tready;
        pop_en       = enable && (state_q == ST_STREAM) && m_tready && (count_q != '0);
        underrun_evt = enable && (state_q == ST_STREAM) && m_tready && (count_q == '0);
    end

    // Pointer, occupancy and output-word datapath; dropping enable flushes everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = 1'b1;

        if (!enable) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            m_tdata_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case ({wr_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            unique case (state_q)
                ST_STREAM: begin
                    if (pop_en) begin
                        m_tdata_d = mem_q[rd_ptr_q];
                    end else if (underrun_evt) begin
                        m_tdata_d = '0;
                    end
                end
                default: m_tdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; count and pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= s_tdata;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;

`ifdef DAC_TX_FIFO_STATUS_EN
    logic [15:0] underrun_count_q, underrun_count_d;

    always_comb begin
        underrun_count_d = underrun_count_q;
        if (underrun_evt && (underrun_count_q != 16'hFFFF)) begin
            underrun_count_d = underrun_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            underrun_count_q <= '0;
        end else begin
            underrun_count_q <= underrun_count_d;
        end
    end

    assign fifo_level     = count_q;
    assign underrun_count = underrun_count_q;
`else
    assign fifo_level     = '0;
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_dac_tx_fifo.sv
// Directed bench for dac_tx_fifo: prefill, backpressure at full, underrun recovery, ordering, flush, thresholds.
module tb_dac_tx_fifo;

    localparam int NL    = 8;
    localparam int AW    = 5;
    localparam int DW    = 2 * 16 * NL;
    localparam int DEPTH = 2 ** AW;

    logic            clock = 1'b0;
    logic            resetn;
    logic            enable;
    logic [AW:0]     prefill_level;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [AW:0]     fifo_level;
    logic [15:0]     underrun_count;

    int              checks   = 0;
    int              failures = 0;
    int              seq      = 0;
    logic [DW-1:0]   sb [$];

    dac_tx_fifo #(
        .NUMBER_OF_LINE (NL),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .enable         (enable),
        .prefill_level  (prefill_level),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mkword(input int n);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(n);
        return {NL{w}};
    endfunction

    // Status ports only carry information when the status build is selected.
    function automatic logic [DW-1:0] exp_status(input int v);
`ifdef DAC_TX_FIFO_STATUS_EN
        return DW'(v);
`else
        return DW'(v - v);
`endif
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepted words enter the scoreboard as the clock edge that writes them arrives.
    task automatic tick();
        if (s_tvalid && s_tready) sb.push_back(s_tdata);
        @(posedge clock);
        #1;
    endtask

    task automatic drive_word();
        s_tdata  = mkword(seq);
        s_tvalid = 1'b1;
        seq++;
    endtask

    task automatic expect_pop(input string tag);
        logic [DW-1:0] e;
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        check(tag, m_tdata, e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn        = 1'b0;
        enable        = 1'b0;
        prefill_level = '0;
        s_tdata       = '0;
        s_tvalid      = 1'b0;
        m_tready      = 1'b0;
        repeat (2) tick();

        // Reset values
        check("reset_s_tready", DW'(s_tready), DW'(1'b0));
        check("reset_m_tvalid", DW'(m_tvalid), DW'(1'b0));
        check("reset_m_tdata", m_tdata, '0);
        check("reset_level", DW'(fifo_level), exp_status(0));
        check("reset_ucnt", DW'(underrun_count), exp_status(0));

        resetn = 1'b1;
        tick();
        check("idle_m_tvalid", DW'(m_tvalid), DW'(1'b1));
        check("idle_s_tready", DW'(s_tready), DW'(1'b0));

        // Prefill of 4, then the first pop one cycle after m_tready
        enable        = 1'b1;
        prefill_level = 4;
        tick();
        check("prefill_s_tready", DW'(s_tready), DW'(1'b1));
        for (int i = 0; i < 4; i++) begin
            drive_word();
            tick();
            check("prefill_m_tdata", m_tdata, '0);
        end
        check("prefill_level", DW'(fifo_level), exp_status(4));
        s_tvalid = 1'b0;
        tick();
        check("stream_entry_m_tdata", m_tdata, '0);
        m_tready = 1'b1;
        tick();
        expect_pop("first_word");
        m_tready = 1'b0;
        repeat (2) tick();
        check("hold_m_tdata", m_tdata, mkword(0));
        check("hold_level", DW'(fifo_level), exp_status(3));

        // Drain to empty: zero output, one-cycle UNDERRUN, back through PREFILL
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pop("drain");
        end
        tick();
        expect_pop("underrun_data");
        check("underrun_ucnt", DW'(underrun_count), exp_status(1));
        prefill_level = 1;
        drive_word();
        tick();
        s_tvalid = 1'b0;
        check("underrun_exit_data", m_tdata, '0);
        tick();
        check("reprefill_data", m_tdata, '0);
        tick();
        expect_pop("after_underrun");
        check("ucnt_single", DW'(underrun_count), exp_status(1));
        m_tready = 1'b0;
        enable   = 1'b0;
        tick();
        sb.delete();
        check("flush_s_tready", DW'(s_tready), DW'(1'b0));
        check("flush_m_tdata", m_tdata, '0);
        check("flush_level", DW'(fifo_level), exp_status(0));

        // Fill to DEPTH with the DAC stalled; the extra word must be refused
        enable        = 1'b1;
        prefill_level = DEPTH;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive_word();
            tick();
        end
        check("full_s_tready", DW'(s_tready), DW'(1'b0));
        check("full_level", DW'(fifo_level), exp_status(DEPTH));
        drive_word();
        tick();
        check("full_reject", DW'(s_tready), DW'(1'b0));
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            expect_pop("full_drain");
        end
        tick();
        expect_pop("full_underrun");
        check("full_ucnt", DW'(underrun_count), exp_status(2));
        m_tready = 1'b0;
        enable   = 1'b0;
        tick();
        sb.delete();

        // Continuous write and pop at a steady occupancy of 10
        enable        = 1'b1;
        prefill_level = 10;
        tick();
        for (int i = 0; i < 10; i++) begin
            drive_word();
            tick();
        end
        s_tvalid = 1'b0;
        tick();
        check("steady_level", DW'(fifo_level), exp_status(10));
        m_tready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            drive_word();
            tick();
            expect_pop("stream_order");
        end
        check("cont_level", DW'(fifo_level), exp_status(10));
        check("cont_s_tready", DW'(s_tready), DW'(1'b1));

        // Drop enable with 7 words queued; re-enable needs a full prefill again
        s_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pop("drain_to_7");
        end
        check("level_7", DW'(fifo_level), exp_status(7));
        m_tready = 1'b0;
        enable   = 1'b0;
        tick();
        sb.delete();
        check("disable_s_tready", DW'(s_tready), DW'(1'b0));
        check("disable_m_tdata", m_tdata, '0);
        check("disable_level", DW'(fifo_level), exp_status(0));
        enable        = 1'b1;
        prefill_level = 4;
        m_tready      = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive_word();
            tick();
            check("reen_m_tdata", m_tdata, '0);
        end
        s_tvalid = 1'b0;
        repeat (2) tick();
        check("reen_wait", m_tdata, '0);
        drive_word();
        tick();
        s_tvalid = 1'b0;
        tick();
        check("reen_entry", m_tdata, '0);
        tick();
        expect_pop("reen_first");
        m_tready = 1'b0;
        enable   = 1'b0;
        tick();
        sb.delete();

        // prefill_level=0 behaves as a threshold of 1
        enable        = 1'b1;
        prefill_level = 0;
        m_tready      = 1'b1;
        tick();
        drive_word();
        tick();
        s_tvalid = 1'b0;
        check("pf0_write", m_tdata, '0);
        tick();
        check("pf0_entry", m_tdata, '0);
        tick();
        expect_pop("pf0_first");
        m_tready = 1'b0;
        enable   = 1'b0;
        tick();
        sb.delete();

        // prefill_level=63 clamps to DEPTH
        enable        = 1'b1;
        prefill_level = 63;
        m_tready      = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive_word();
            tick();
        end
        s_tvalid = 1'b0;
        tick();
        check("pf63_entry", m_tdata, '0);
        tick();
        expect_pop("pf63_first");
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick();
            expect_pop("pf63_drain");
        end
        tick();
        expect_pop("pf63_underrun");
        check("pf63_ucnt", DW'(underrun_count), exp_status(3));
        check("final_m_tvalid", DW'(m_tvalid), DW'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_tx_fifo.md
DAC_TX_FIFO -- requirements
Module: dac_tx_fifo

Interface
REQ-001 Parameter NUMBER_OF_LINE, default 8, is the number of IQ sample pairs per beat; the data width is DW = 2*16*NUMBER_OF_LINE.
REQ-002 Parameter ADDR_WIDTH, default 5, sets the FIFO depth to DEPTH = 2**ADDR_WIDTH words.
REQ-003 Port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 Port enable, input, 1 bit: streaming enable from the control registers.
REQ-006 Port prefill_level, input, ADDR_WIDTH+1 bits: FIFO occupancy required before streaming starts.
REQ-007 Port s_tdata, input, DW bits: interleaved IQ words from the transmit core.
REQ-008 Port s_tvalid, input, 1 bit: upstream word valid.
REQ-009 Port s_tready, output, 1 bit: FIFO can accept a word.
REQ-010 Port m_tdata, output, DW bits: registered word to the DAC.
REQ-011 Port m_tvalid, output, 1 bit: DAC data valid.
REQ-012 Port m_tready, input, 1 bit: DAC consumes the current word.
REQ-013 Port fifo_level, output, ADDR_WIDTH+1 bits: current FIFO occupancy.
REQ-014 Port underrun_count, output, 16 bits: number of underrun events.

Function
REQ-015 The FSM SHALL have four states:
- IDLE
- PREFILL
- STREAM
- UNDERRUN
REQ-016 In any state, enable=0 SHALL force IDLE on the next cycle and flush the FIFO (pointers and count to 0).
REQ-017 IDLE SHALL hold s_tready=0, hold m_tdata=0, and move to PREFILL on the cycle after enable=1.
REQ-018 A write SHALL occur when s_tvalid && s_tready, in PREFILL/STREAM/UNDERRUN only.
- s_tready = (count < DEPTH), decoded from the registered count.
- s_tready = 0 in IDLE.
REQ-019 The effective threshold SHALL be derived from prefill_level as follows:
- 0 is treated as 1.
- Values > DEPTH are clamped to DEPTH.
REQ-020 PREFILL SHALL hold m_tdata=0 and SHALL go to STREAM when count >= effective threshold.
REQ-021 In STREAM, with m_tready=1 and count>0, one word SHALL be popped and appear on m_tdata on the next cycle (1-cycle read latency).
REQ-022 In STREAM, with m_tready=0, m_tdata and the FIFO SHALL hold unchanged.
REQ-023 In STREAM, with m_tready=1 and count=0:
- m_tdata SHALL become 0 on the next cycle.
- The FSM SHALL go to UNDERRUN.
- underrun_count SHALL increment, saturating at 16'hFFFF.
REQ-024 UNDERRUN SHALL last exactly one cycle with m_tdata=0, then go to PREFILL.
REQ-025 A simultaneous write and pop SHALL leave count unchanged.
- Write is blocked at full.
- Pop is blocked at empty, and that case counts as an underrun.
REQ-026 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-027 m_tvalid SHALL be 1 in every state outside reset, so the DAC stream is continuous.

Reset
REQ-028 With resetn=0 at a clock edge, the block SHALL reset to the following values:
- State = IDLE.
- Pointers, count, fifo_level = 0.
- m_tdata = 0, m_tvalid = 0, s_tready = 0.
- underrun_count = 0.
REQ-029 A reset asserted mid-stream SHALL discard all FIFO contents; streaming SHALL resume only through PREFILL.

Configuration
REQ-030 Macro DAC_TX_FIFO_STATUS_EN controls the status outputs; the ports fifo_level and underrun_count exist in both builds.
- Defined: fifo_level mirrors count every cycle, and underrun_count behaves per REQ-023.
- Undefined: both ports are tied to 0 and the counter is not synthesized; all other behaviour is identical.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, then enable=1, prefill_level=4, 4 writes: STREAM entered the cycle after count=4; first word appears on m_tdata 1 cycle after the first m_tready pop.
- 32 writes with m_tready=0 (DEPTH=32): s_tready=0 when count=32; the 33rd word is not accepted; fifo_level=32.
- STREAM, m_tready=1, s_tvalid=0 until empty: m_tdata=0, UNDERRUN for 1 cycle, then PREFILL; underrun_count=1.
- Continuous write and pop at count=10: count stays at 10; output order equals input order over 1000 beats.
- enable dropped mid-stream with count=7: IDLE next cycle, count=0, m_tdata=0; re-enable requires a full prefill.
- prefill_level=0 and prefill_level=63: thresholds of 1 and 32 respectively.
